// File: rtl/axitoahbl_pkg.sv
// Shared definitions for the AXI-to-AHB-Lite bridge inbound register slices.
//   skid_state_e      : occupancy state of the two-entry skid buffer
//   w_payload_width() : packed width of one W beat {WID, WDATA, WSTRB, WLAST}
package axitoahbl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,   // neither register holds a beat
        ST_ONE   = 2'b01,   // main register holds a beat
        ST_FULL  = 2'b10    // main and skid registers both hold a beat
    } skid_state_e;

    function automatic int unsigned w_payload_width(input int unsigned id_width,
                                                    input int unsigned data_width);
        return id_width + data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/axitoahbl_skid_buf.sv
// Two-entry skid buffer (full register slice) for a valid/ready channel.
// Every output is driven straight from a flop, so no combinational path
// crosses the slice in either direction, yet it still moves one beat per clock.
//   clk_i, rst_ni        : clock (rising edge), asynchronous active-low reset
//   in_data_i/valid_i    : upstream payload and valid
//   in_ready_o           : registered ready to upstream
//   out_data_o/valid_o   : registered payload and valid to downstream
//   out_ready_i          : ready from downstream
module axitoahbl_skid_buf
    import axitoahbl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             accept;
    logic             pop;

    assign accept = in_valid_i & ready_q;
    assign pop    = valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_data_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_d = in_data_i;
                end else if (accept) begin
                    skid_d  = in_data_i;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // ready_q is low here, so only a pop can occur
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                // unused encoding: drop whatever is held and reopen
                state_d = ST_EMPTY;
            end
        endcase
        // ready and valid are registered copies of the next-state decode,
        // which is what lets ready lag the downstream stall by one cycle
        ready_d = (state_d != ST_FULL);
        valid_d = (state_d == ST_ONE) || (state_d == ST_FULL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_data_o  = main_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/axitoahbl_axi_w_in_slice.sv
// Inbound AXI write-data (W) channel register slice between the external AXI
// master and the AXI slave controller. Payload is carried opaquely.
//   ACLK, ARESETN                       : clock, asynchronous active-low reset
//   WID/WDATA/WSTRB/WLAST/WVALID        : W channel from the AXI master
//   WREADY                              : registered ready to the AXI master
//   WIDIn/WDATAIn/WSTRBIn/WLASTIn/WVALIDIn : registered W channel to controller
//   WREADYIn                            : ready from the slave controller
module axitoahbl_axi_w_in_slice
    import axitoahbl_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ID_WIDTH-1:0]     WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     WIDIn,
    output logic [DATA_WIDTH-1:0]   WDATAIn,
    output logic [DATA_WIDTH/8-1:0] WSTRBIn,
    output logic                    WLASTIn,
    output logic                    WVALIDIn,
    input  logic                    WREADYIn
);

    localparam int unsigned PW = w_payload_width(ID_WIDTH, DATA_WIDTH);

    logic [PW-1:0] w_in;
    logic [PW-1:0] w_out;

    assign w_in = {WID, WDATA, WSTRB, WLAST};

    axitoahbl_skid_buf #(
        .WIDTH (PW)
    ) u_skid (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .in_data_i   (w_in),
        .in_valid_i  (WVALID),
        .in_ready_o  (WREADY),
        .out_data_o  (w_out),
        .out_valid_o (WVALIDIn),
        .out_ready_i (WREADYIn)
    );

    assign {WIDIn, WDATAIn, WSTRBIn, WLASTIn} = w_out;

endmodule

// File: tb/tb_axitoahbl_axi_w_in_slice.sv
module tb_axitoahbl_axi_w_in_slice;

    typedef logic [127:0] chk_t;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  WID;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  WIDIn;
    logic [63:0] WDATAIn;
    logic [7:0]  WSTRBIn;
    logic        WLASTIn;
    logic        WVALIDIn;
    logic        WREADYIn;

    logic [1:0]  n32_WID;
    logic [31:0] n32_WDATA;
    logic [3:0]  n32_WSTRB;
    logic        n32_WLAST;
    logic        n32_WVALID;
    logic        n32_WREADY;
    logic [1:0]  n32_WIDIn;
    logic [31:0] n32_WDATAIn;
    logic [3:0]  n32_WSTRBIn;
    logic        n32_WLASTIn;
    logic        n32_WVALIDIn;
    logic        n32_WREADYIn;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    axitoahbl_axi_w_in_slice #(
        .ID_WIDTH   (4),
        .DATA_WIDTH (64)
    ) u_dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .WID      (WID),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WIDIn    (WIDIn),
        .WDATAIn  (WDATAIn),
        .WSTRBIn  (WSTRBIn),
        .WLASTIn  (WLASTIn),
        .WVALIDIn (WVALIDIn),
        .WREADYIn (WREADYIn)
    );

    axitoahbl_axi_w_in_slice #(
        .ID_WIDTH   (2),
        .DATA_WIDTH (32)
    ) u_dut32 (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .WID      (n32_WID),
        .WDATA    (n32_WDATA),
        .WSTRB    (n32_WSTRB),
        .WLAST    (n32_WLAST),
        .WVALID   (n32_WVALID),
        .WREADY   (n32_WREADY),
        .WIDIn    (n32_WIDIn),
        .WDATAIn  (n32_WDATAIn),
        .WSTRBIn  (n32_WSTRBIn),
        .WLASTIn  (n32_WLASTIn),
        .WVALIDIn (n32_WVALIDIn),
        .WREADYIn (n32_WREADYIn)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input chk_t got, input chk_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // ---------------- scoreboard for the random phase ----------------
    logic [76:0] exp_q[$];
    logic        sb_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [76:0] held;
    logic [76:0] cur_out;
    logic [76:0] exp_beat;

    // Negedge sampling: inputs change just after posedge, so these values
    // are exactly what the next rising edge will see.
    always @(negedge ACLK) begin
        if (sb_en) begin
            cur_out = {WIDIn, WDATAIn, WSTRBIn, WLASTIn};
            if (WVALID && WREADY) exp_q.push_back({WID, WDATA, WSTRB, WLAST});
            if (stall_prev) begin
                check("stall_valid", chk_t'(WVALIDIn), chk_t'(1));
                check("stall_payload", chk_t'(cur_out), chk_t'(held));
            end
            if (WVALIDIn && WREADYIn) begin
                check("sb_nonempty", chk_t'(exp_q.size() != 0), chk_t'(1));
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check("sb_beat", chk_t'(cur_out), chk_t'(exp_beat));
                end
            end
            stall_prev = WVALIDIn && !WREADYIn;
            held       = cur_out;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; WREADYIn = 1'b0;
        n32_WID = '0; n32_WDATA = '0; n32_WSTRB = '0; n32_WLAST = 1'b0;
        n32_WVALID = 1'b0; n32_WREADYIn = 1'b0;

        // ---- reset hold and release ----
        repeat (3) begin
            tick();
            check("rst_wready", chk_t'(WREADY), chk_t'(0));
            check("rst_wvalidin", chk_t'(WVALIDIn), chk_t'(0));
            check("rst_payload", chk_t'({WIDIn, WDATAIn, WSTRBIn, WLASTIn}), chk_t'(0));
        end
        ARESETN = 1'b1;
        #1;
        check("rel_wready_pre", chk_t'(WREADY), chk_t'(0));
        tick();
        check("rel_wready", chk_t'(WREADY), chk_t'(1));
        check("rel_wvalidin", chk_t'(WVALIDIn), chk_t'(0));
        check("rel_payload", chk_t'({WIDIn, WDATAIn, WSTRBIn, WLASTIn}), chk_t'(0));

        // ---- streaming 8 beats ----
        WREADYIn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            WVALID = 1'b1;
            WID    = 4'(i);
            WDATA  = 64'(i);
            WSTRB  = 8'hFF;
            WLAST  = (i == 8);
            tick();
            check("str_valid", chk_t'(WVALIDIn), chk_t'(1));
            check("str_data", chk_t'(WDATAIn), chk_t'(i));
            check("str_id", chk_t'(WIDIn), chk_t'(i));
            check("str_last", chk_t'(WLASTIn), chk_t'(i == 8));
            check("str_wready", chk_t'(WREADY), chk_t'(1));
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        tick();
        check("str_end_valid", chk_t'(WVALIDIn), chk_t'(0));

        // ---- stall: 0xA held, 0xB in skid ----
        WREADYIn = 1'b0;
        WVALID = 1'b1; WDATA = 64'hA; WID = 4'h3;
        tick();
        check("stl_a_valid", chk_t'(WVALIDIn), chk_t'(1));
        check("stl_a_data", chk_t'(WDATAIn), chk_t'(64'hA));
        check("stl_a_wready", chk_t'(WREADY), chk_t'(1));
        WDATA = 64'hB; WID = 4'h4;
        tick();
        check("stl_b_wready", chk_t'(WREADY), chk_t'(0));
        check("stl_b_data", chk_t'(WDATAIn), chk_t'(64'hA));
        WVALID = 1'b0;
        tick();
        check("stl_hold_data", chk_t'(WDATAIn), chk_t'(64'hA));
        check("stl_hold_id", chk_t'(WIDIn), chk_t'(4'h3));
        check("stl_hold_wready", chk_t'(WREADY), chk_t'(0));
        WREADYIn = 1'b1;
        tick();
        check("stl_rel_data", chk_t'(WDATAIn), chk_t'(64'hB));
        check("stl_rel_valid", chk_t'(WVALIDIn), chk_t'(1));
        check("stl_rel_wready", chk_t'(WREADY), chk_t'(1));
        tick();
        check("stl_drain_valid", chk_t'(WVALIDIn), chk_t'(0));
        check("stl_drain_wready", chk_t'(WREADY), chk_t'(1));

        // ---- reset while FULL with 0xC/0xD ----
        WREADYIn = 1'b0;
        WVALID = 1'b1; WDATA = 64'hC;
        tick();
        WDATA = 64'hD;
        tick();
        WVALID = 1'b0;
        check("mrst_full_wready", chk_t'(WREADY), chk_t'(0));
        check("mrst_full_data", chk_t'(WDATAIn), chk_t'(64'hC));
        ARESETN = 1'b0;
        #1;
        check("mrst_valid", chk_t'(WVALIDIn), chk_t'(0));
        check("mrst_data", chk_t'(WDATAIn), chk_t'(0));
        check("mrst_wready", chk_t'(WREADY), chk_t'(0));
        tick();
        tick();
        ARESETN = 1'b1;
        WREADYIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_no_stale", chk_t'(WVALIDIn), chk_t'(0));
        end
        WVALID = 1'b1; WDATA = 64'hE;
        tick();
        check("mrst_e_data", chk_t'(WDATAIn), chk_t'(64'hE));
        WVALID = 1'b0;
        tick();
        check("mrst_e_only", chk_t'(WVALIDIn), chk_t'(0));

        // ---- random backpressure, 1000 beats ----
        begin
            int unsigned sent = 0;
            int unsigned cyc  = 0;
            logic        acc;
            sb_en  = 1'b1;
            WVALID = 1'b0;
            while (sent < 1000 && cyc < 20000) begin
                @(negedge ACLK);
                acc = WVALID && WREADY;
                if (acc) sent++;
                @(posedge ACLK);
                #1;
                cyc++;
                if (!WVALID || acc) begin
                    WVALID = (sent < 1000) && ($urandom_range(0, 3) != 0);
                    WID    = 4'($urandom);
                    WDATA  = {$urandom, $urandom};
                    WSTRB  = 8'($urandom);
                    WLAST  = 1'($urandom);
                end
                WREADYIn = ($urandom_range(0, 3) != 0);
            end
            WVALID   = 1'b0;
            WREADYIn = 1'b1;
            check("rand_sent", chk_t'(sent), chk_t'(1000));
            for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
            tick();
            check("rand_drained", chk_t'(exp_q.size()), chk_t'(0));
            check("rand_idle", chk_t'(WVALIDIn), chk_t'(0));
            sb_en = 1'b0;
        end

        // ---- 32-bit data / 2-bit ID variant ----
        n32_WREADYIn = 1'b1;
        n32_WVALID   = 1'b1;
        n32_WID      = 2'b10;
        n32_WDATA    = 32'hDEADBEEF;
        n32_WSTRB    = 4'b0101;
        n32_WLAST    = 1'b1;
        tick();
        check("w32_valid", chk_t'(n32_WVALIDIn), chk_t'(1));
        check("w32_strb", chk_t'(n32_WSTRBIn), chk_t'(4'b0101));
        check("w32_id", chk_t'(n32_WIDIn), chk_t'(2'b10));
        check("w32_data", chk_t'(n32_WDATAIn), chk_t'(32'hDEADBEEF));
        check("w32_last", chk_t'(n32_WLASTIn), chk_t'(1));
        n32_WID   = 2'b01;
        n32_WSTRB = 4'b1010;
        n32_WLAST = 1'b0;
        tick();
        check("w32_strb2", chk_t'(n32_WSTRBIn), chk_t'(4'b1010));
        check("w32_id2", chk_t'(n32_WIDIn), chk_t'(2'b01));
        check("w32_last2", chk_t'(n32_WLASTIn), chk_t'(0));
        n32_WVALID = 1'b0;
        tick();
        check("w32_idle", chk_t'(n32_WVALIDIn), chk_t'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
